uart_packet_decoder: RTL

UART_PACKET_DECODER -- requirements
Module: uart_packet_decoder

---
 rtl/uart_packet_decoder_if.sv | 34 +++
 rtl/uart_packet_decoder.sv | 93 +++++++++
 2 files changed

// File: rtl/uart_packet_decoder_if.sv
// uart_packet_decoder_if: byte-stream input and write-request output bundle of the packet decoder
//   uart_rx_valid/uart_rx_data   received byte strobe and value
//   parity_error                 byte fault, qualified by uart_rx_valid
//   stop_bit_unstable            level line fault from the receiver
//   out_valid/out_ready          write request handshake
//   out_address/out_data         pending write address and byte
//   packet_done/error            one-cycle completion / abort pulses
//   overflow_sticky              set when a payload byte had to be dropped
//   master: decoder side, slave: byte source and write consumer side
interface uart_packet_decoder_if #(
    parameter int ADDRESS_WIDTH = 32
);
    logic                     uart_rx_valid;
    logic [7:0]               uart_rx_data;
    logic                     parity_error;
    logic                     stop_bit_unstable;
    logic                     out_valid;
    logic                     out_ready;
    logic [ADDRESS_WIDTH-1:0] out_address;
    logic [7:0]               out_data;
    logic                     packet_done;
    logic                     error;
    logic                     overflow_sticky;

    modport master (
        input  uart_rx_valid, uart_rx_data, parity_error, stop_bit_unstable, out_ready,
        output out_valid, out_address, out_data, packet_done, error, overflow_sticky
    );

    modport slave (
        output uart_rx_valid, uart_rx_data, parity_error, stop_bit_unstable, out_ready,
        input  out_valid, out_address, out_data, packet_done, error, overflow_sticky
    );
endinterface

// File: rtl/uart_packet_decoder.sv
// uart_packet_decoder: turns MAGIC/LEN/ADDR/payload byte packets into addressed byte write requests
//   clock  rising-edge clock
//   clear  asynchronous active-high reset
//   bus    uart_packet_decoder_if.master: rx byte stream in, write request, status pulses out
module uart_packet_decoder #(
    parameter logic [7:0] MAGIC = 8'h51,
    parameter int ADDRESS_WIDTH = 32
) (
    input logic clock,
    input logic clear,
    uart_packet_decoder_if.master bus
);
    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, ADDR, DATA} state_t;
    state_t                   state;
    logic [15:0]              len;
    logic [15:0]              index;
    logic [1:0]               addr_index;
    logic [ADDRESS_WIDTH-1:0] addr;
    logic                     fault;

    always_comb fault = (bus.uart_rx_valid && bus.parity_error) || bus.stop_bit_unstable;

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state               <= IDLE;
            len                 <= '0;
            index               <= '0;
            addr_index          <= '0;
            addr                <= '0;
            bus.out_valid       <= 1'b0;
            bus.out_address     <= '0;
            bus.out_data        <= '0;
            bus.packet_done     <= 1'b0;
            bus.error           <= 1'b0;
            bus.overflow_sticky <= 1'b0;
        end else begin
            bus.packet_done <= 1'b0;
            bus.error       <= 1'b0;
            // accept retires the request; a payload byte below may reload it in the same cycle
            if (bus.out_valid && bus.out_ready)
                bus.out_valid <= 1'b0;
            // line faults abort a packet in progress but are silent while idle
            if (fault) begin
                bus.error <= state != IDLE;
                state     <= IDLE;
            end else if (bus.uart_rx_valid) begin
                case (state)
                    IDLE: begin
                        if (bus.uart_rx_data == MAGIC)
                            state <= LEN_HI;
                    end
                    LEN_HI: begin
                        len[15:8] <= bus.uart_rx_data;
                        state     <= LEN_LO;
                    end
                    LEN_LO: begin
                        len[7:0]   <= bus.uart_rx_data;
                        addr_index <= '0;
                        addr       <= '0;
                        state      <= ADDR;
                    end
                    ADDR: begin
                        addr       <= (addr << 8) | ADDRESS_WIDTH'(bus.uart_rx_data);
                        addr_index <= addr_index + 2'd1;
                        index      <= '0;
                        if (addr_index == 2'd3) begin
                            state           <= len == 16'd0 ? IDLE : DATA;
                            bus.packet_done <= len == 16'd0;
                        end
                    end
                    DATA: begin
                        // a still-unaccepted request cannot take another byte: drop and abort
                        if (bus.out_valid && !bus.out_ready) begin
                            bus.overflow_sticky <= 1'b1;
                            bus.error           <= 1'b1;
                            state               <= IDLE;
                        end else begin
                            bus.out_valid   <= 1'b1;
                            bus.out_data    <= bus.uart_rx_data;
                            bus.out_address <= addr + ADDRESS_WIDTH'(index);
                            index           <= index + 16'd1;
                            if (index == len - 16'd1) begin
                                bus.packet_done <= 1'b1;
                                state           <= IDLE;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
